// File: rtl/mem_access_sequencer_pkg.sv
// mem_access_sequencer_pkg
//   Shared types for the MEM-stage access sequencer.
//   - memseq_state_t : sequencer FSM state encoding.
//   - BE_ALL / BE_LOW / BE_HIGH : byte-lane enables for the 16-bit datapath.
package mem_access_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INDIR  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } memseq_state_t;

  localparam logic [1:0] BE_ALL  = 2'b11;
  localparam logic [1:0] BE_LOW  = 2'b01;
  localparam logic [1:0] BE_HIGH = 2'b10;

endpackage

// File: rtl/mem_access_sequencer_byte_lane_unit.sv
// byte_lane_unit
//   Combinational byte-lane steering for the memory port.
//   Ports:
//     addr_lo_i  byte offset within the word (cur_addr low bits)
//     byte_i     byte access; otherwise full word
//     wdata_i    store source value
//     rdata_i    memory read data
//     be_o       lane enables (all lanes for word access)
//     wdata_o    write data; byte stores replicate the low byte in every lane
//     rbyte_o    lane selected by addr_lo_i, zero-extended to DATA_WIDTH
module byte_lane_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = DATA_WIDTH / 8,
  parameter int OFS_W      = $clog2(NUM_LANES)
) (
  input  logic [OFS_W-1:0]      addr_lo_i,
  input  logic                  byte_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [NUM_LANES-1:0]  be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rbyte_o
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign be_o[g]          = !byte_i || (addr_lo_i == OFS_W'(g));
    assign wdata_o[g*8 +: 8] = byte_i ? wdata_i[7:0] : wdata_i[g*8 +: 8];
  end

  logic [7:0] sel;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (addr_lo_i == OFS_W'(i)) sel = rdata_i[i*8 +: 8];
  end

  assign rbyte_o = DATA_WIDTH'(sel);

endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Multi-cycle MEM-stage sequencer: word/byte load/store with up to
//   MAX_INDIRECT levels of pointer indirection. Stalls the pipeline until the
//   data-memory handshake completes, then pulses resp_valid for one cycle.
//   Optional macro MEMSEQ_TIMEOUT_EN adds a wait watchdog (TIMEOUT_CYCLES)
//   that aborts a stuck access with resp_error.
//   Ports:
//     clk, rst_n                      clock, synchronous active-low reset
//     req_valid/read/write/byte       request qualifiers from MEM stage
//     req_levels, req_addr, req_wdata indirection depth, address, store data
//     stall                           freeze upstream pipeline
//     resp_valid/rdata/error          completion pulse, load data, abort flag
//     mem_address/read/write          data-memory request
//     mem_byte_enable, mem_wdata      lane enables, write data
//     mem_rdata, mem_resp             memory read data, one-cycle completion
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int MAX_INDIRECT = 1,
  parameter int LVL_W        = $clog2(MAX_INDIRECT + 1)
`ifdef MEMSEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic [LVL_W-1:0]        req_levels,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    stall,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_error,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int OFS_W     = $clog2(NUM_LANES);
  localparam int PTR_W     = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

  memseq_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  byte_q, byte_d;
  logic                  write_q, write_d;
  logic [LVL_W-1:0]      lvl_q, lvl_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  start, in_indir, in_access, strobe_on;
  logic [LVL_W-1:0]      lvl_in, lvl_dec;
  logic [PTR_W-1:0]      ptr_ext;
  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic [NUM_LANES-1:0]  lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata, lane_rbyte;

  // Only clamp when the level field can encode values above MAX_INDIRECT.
  if (((1 << LVL_W) - 1) > MAX_INDIRECT) begin : g_clamp
    assign lvl_in = (req_levels > LVL_W'(MAX_INDIRECT)) ? LVL_W'(MAX_INDIRECT) : req_levels;
  end else begin : g_noclamp
    assign lvl_in = req_levels;
  end

  assign start     = (state_q == IDLE) && req_valid && (req_read || req_write);
  assign in_indir  = (state_q == INDIR);
  assign in_access = (state_q == ACCESS);
  assign strobe_on = in_indir || in_access;
  assign lvl_dec   = lvl_q - LVL_W'(1);
  assign ptr_ext   = PTR_W'(mem_rdata);

  if (OFS_W > 0) begin : g_align
    assign addr_aligned = {addr_q[ADDR_WIDTH-1:OFS_W], OFS_W'(0)};
  end else begin : g_noalign
    assign addr_aligned = addr_q;
  end

  byte_lane_unit #(.DATA_WIDTH(DATA_WIDTH)) u_lanes (
    .addr_lo_i (addr_q[OFS_W-1:0]),
    .byte_i    (byte_q),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rbyte_o   (lane_rbyte)
  );

`ifdef MEMSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             expired;
  // Counter value of the final allowed wait cycle; no response by then aborts.
  assign expired = strobe_on && !mem_resp && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    byte_d  = byte_q;
    write_d = write_q;
    lvl_d   = lvl_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (start) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        byte_d  = req_byte;
        write_d = req_write;           // read+write together is a store
        lvl_d   = lvl_in;
        state_d = (lvl_in != '0) ? INDIR : ACCESS;
      end
      INDIR: if (mem_resp) begin
        addr_d  = ptr_ext[ADDR_WIDTH-1:0];
        lvl_d   = lvl_dec;
        state_d = (lvl_dec != '0) ? INDIR : ACCESS;
      end
      ACCESS: if (mem_resp) begin
        state_d = DONE;
        if (!write_q) rdata_d = byte_q ? lane_rbyte : mem_rdata;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MEMSEQ_TIMEOUT_EN
    err_d = err_q;
    if (start) err_d = 1'b0;
    if (start || mem_resp || !strobe_on) cnt_d = '0;
    else                                 cnt_d = cnt_q + CNT_W'(1);
    if (expired) begin
      state_d = DONE;
      err_d   = 1'b1;
      rdata_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      byte_q  <= 1'b0;
      write_q <= 1'b0;
      lvl_q   <= '0;
      rdata_q <= '0;
`ifdef MEMSEQ_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      byte_q  <= byte_d;
      write_q <= write_d;
      lvl_q   <= lvl_d;
      rdata_q <= rdata_d;
`ifdef MEMSEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign stall           = start || strobe_on;
  assign resp_valid      = (state_q == DONE);
  assign resp_rdata      = rdata_q;
`ifdef MEMSEQ_TIMEOUT_EN
  assign resp_error      = (state_q == DONE) && err_q;
`else
  assign resp_error      = 1'b0;
`endif
  // Outside an active strobe the port idles at its reset values.
  assign mem_read        = in_indir || (in_access && !write_q);
  assign mem_write       = in_access && write_q;
  assign mem_address     = strobe_on ? addr_aligned : '0;
  assign mem_byte_enable = in_access ? lane_be : '1;
  assign mem_wdata       = (in_access && write_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_read, req_write, req_byte;
  logic [1:0]  req_levels;
  logic [15:0] req_addr, req_wdata;
  logic        stall, resp_valid, resp_error;
  logic [15:0] resp_rdata, mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_byte_enable;

  mem_access_sequencer #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_INDIRECT(2), .LVL_W(2)
`ifdef MEMSEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_byte(req_byte), .req_levels(req_levels),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic wr; logic [1:0] be; logic [15:0] wd; } acc_t;
  typedef struct { logic [15:0] rd; logic err; } res_t;

  acc_t        acc_q[$];
  res_t        res_q[$];
  logic [15:0] mem [int];
  int          n_vec = 0, n_err = 0;
  int          waits = 0;
  logic        hang = 1'b0, inj_resp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_mem(input int a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  task automatic push_acc(input logic [15:0] a, input logic wr, input logic [1:0] be, input logic [15:0] wd);
    acc_t e;
    e.a = a; e.wr = wr; e.be = be; e.wd = wd;
    acc_q.push_back(e);
  endtask

  task automatic push_res(input logic [15:0] rd, input logic err);
    res_t r;
    r.rd = rd; r.err = err;
    res_q.push_back(r);
  endtask

  // Memory model: answers each strobe after `waits` extra cycles.
  initial begin
    int   wcnt;
    int   a;
    acc_t e;
    logic [15:0] cur;
    wcnt = 0; mem_resp = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp = inj_resp;
      if (rst_n && (mem_read || mem_write) && !hang) begin
        if (wcnt >= waits) begin
          wcnt = 0;
          if (acc_q.size() == 0) chk("spurious_acc", 1, 0);
          else begin
            e = acc_q.pop_front();
            chk("acc_addr", mem_address, e.a);
            chk("acc_wr", {mem_write, mem_read}, {e.wr, !e.wr});
            chk("acc_be", mem_byte_enable, e.be);
            if (e.wr) chk("acc_wdata", mem_wdata, e.wd);
            chk("acc_stall", stall, 1);
          end
          a = int'(mem_address);
          if (mem_write) begin
            cur = rd_mem(a);
            if (mem_byte_enable[0]) cur[7:0]  = mem_wdata[7:0];
            if (mem_byte_enable[1]) cur[15:8] = mem_wdata[15:8];
            mem[a] = cur;
          end
          mem_rdata = rd_mem(a);
          mem_resp  = 1'b1;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Result scoreboard.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (res_q.size() == 0) chk("spurious_resp", 1, 0);
        else begin
          r = res_q.pop_front();
          chk("resp_rdata", resp_rdata, r.rd);
          chk("resp_error", resp_error, r.err);
          chk("done_stall", stall, 0);
        end
      end
    end
  end

  task automatic run_req(input string tag, input logic rd, input logic wr, input logic byt,
                         input logic [1:0] lv, input logic [15:0] a, input logic [15:0] wd,
                         input int w, input int exp_lat);
    int lat;
    lat = 0;
    waits = w;
    @(negedge clk);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_byte = byt;
    req_levels = lv; req_addr = a; req_wdata = wd;
    #1 chk({tag, "_stall0"}, stall, 1);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; end
      if (resp_valid) begin lat = c; break; end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, "_idle"}, {stall, mem_read, mem_write}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog sim_time got=expired exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_levels = '0; req_addr = '0; req_wdata = '0;
    mem[16'h1002] = 16'hBEEF;
    mem[16'h2000] = 16'h3005; mem[16'h3004] = 16'h1234;
    mem[16'h5002] = 16'h7F80;
    mem[16'h8000] = 16'h8100; mem[16'h8100] = 16'h8203; mem[16'h8202] = 16'h5A5A;
    mem[16'h9000] = 16'h9101;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {stall, resp_valid, resp_error, mem_read, mem_write}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_byte_enable, 2'b11);
    rst_n = 1'b1;

    // word load, zero wait
    push_acc(16'h1002, 0, 2'b11, 0); push_res(16'hBEEF, 0);
    run_req("ld", 1, 0, 0, 2'd0, 16'h1002, 0, 0, 2);
    // LDI with two wait states per access
    push_acc(16'h2000, 0, 2'b11, 0); push_acc(16'h3004, 0, 2'b11, 0); push_res(16'h1234, 0);
    run_req("ldi", 1, 0, 0, 2'd1, 16'h2000, 0, 2, 7);
    // byte stores, both lanes; rdata holds
    push_acc(16'h4000, 1, 2'b10, 16'hA5A5); push_res(16'h1234, 0);
    run_req("stb_hi", 0, 1, 1, 2'd0, 16'h4001, 16'h00A5, 0, 2);
    push_acc(16'h4000, 1, 2'b01, 16'hA5A5); push_res(16'h1234, 0);
    run_req("stb_lo", 0, 1, 1, 2'd0, 16'h4000, 16'h00A5, 0, 2);
    // byte loads, zero-extended
    push_acc(16'h5002, 0, 2'b10, 0); push_res(16'h007F, 0);
    run_req("ldb_hi", 1, 0, 1, 2'd0, 16'h5003, 0, 0, 2);
    push_acc(16'h5002, 0, 2'b01, 0); push_res(16'h0080, 0);
    run_req("ldb_lo", 1, 0, 1, 2'd0, 16'h5002, 0, 0, 2);
    // word store with wait, then read back
    push_acc(16'h6000, 1, 2'b11, 16'hCAFE); push_res(16'h0080, 0);
    run_req("st", 0, 1, 0, 2'd0, 16'h6000, 16'hCAFE, 1, 3);
    push_acc(16'h6000, 0, 2'b11, 0); push_res(16'hCAFE, 0);
    run_req("ld_back", 1, 0, 0, 2'd0, 16'h6000, 0, 0, 2);
    // read+write together behaves as a store
    push_acc(16'h7000, 1, 2'b11, 16'h1111); push_res(16'hCAFE, 0);
    run_req("rdwr", 1, 1, 0, 2'd0, 16'h7000, 16'h1111, 0, 2);
    // levels=3 clamps to MAX_INDIRECT=2
    push_acc(16'h8000, 0, 2'b11, 0); push_acc(16'h8100, 0, 2'b11, 0);
    push_acc(16'h8202, 0, 2'b11, 0); push_res(16'h5A5A, 0);
    run_req("clamp", 1, 0, 0, 2'd3, 16'h8000, 0, 0, 4);
    // indirect store
    push_acc(16'h9000, 0, 2'b11, 0); push_acc(16'h9100, 1, 2'b11, 16'h4321); push_res(16'h5A5A, 0);
    run_req("sti", 0, 1, 0, 2'd1, 16'h9000, 16'h4321, 0, 3);
    // byte load after the two byte stores
    push_acc(16'h4000, 0, 2'b10, 0); push_res(16'h00A5, 0);
    run_req("ldb_st", 1, 0, 1, 2'd0, 16'h4001, 0, 0, 2);

    // req_valid without read/write: no stall, no transaction
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
    #1 chk("nop_stall", stall, 0);
    @(negedge clk);
    chk("nop_idle", {stall, mem_read, mem_write, resp_valid}, 0);
    req_valid = 1'b0;

    // stray mem_resp in IDLE is ignored
    #2 inj_resp = 1'b1;
    @(negedge clk);
    #2 inj_resp = 1'b0;
    @(negedge clk);
    chk("stray_resp", {stall, mem_read, mem_write, resp_valid}, 0);

    // reset during an ACCESS wait aborts silently
    hang = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_byte = 1'b0; req_levels = 2'd0; req_addr = 16'h1002;
    @(negedge clk);
    req_valid = 1'b0; req_read = 1'b0;
    @(negedge clk);
    chk("mid_rd", mem_read, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst", {mem_read, stall, resp_valid}, 0);
    chk("mid_addr", mem_address, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_quiet", {mem_read, stall}, 0);

`ifdef MEMSEQ_TIMEOUT_EN
    // watchdog: 8 strobe cycles, then DONE with error and zero data
    push_res(16'h0000, 1);
    run_req("tmo", 1, 0, 0, 2'd0, 16'h1002, 0, 0, 9);
`endif
    hang = 1'b0;

    repeat (3) @(negedge clk);
    chk("res_q_empty", res_q.size(), 0);
    chk("acc_q_empty", acc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
